exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- MEM-stage exception arbiter and flush/redirect sequencer for the MIPS pipeline.
- Collects per-instruction exception flags, pending interrupts and ERET, and selects one event by architectural priority.
- Drives the CP0 register file with a single-cycle excepttype/PC/delay-slot/bad-address record.
- Flushes the pipeline and hands the redirect PC (exception vector or EPC) to the fetch stage over a valid/ready handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET.
- DATA_W, 32, width of PC, address and CP0 data buses.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- inst_valid_m  in  1  valid instruction in MEM
- pc_m  in  32  PC of MEM instruction
- in_delayslot_m  in  1  MEM instruction is in a branch delay slot
- mem_addr_m  in  32  load/store effective address
- adel_if_m, adel_ld_m, ades_m, ri_m, ov_m, trap_m, sys_m, bp_m, eret_m  in  1 each  exception flags
- mem_busy_i  in  1  data bus transaction outstanding
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 values
- excepttype_o  out  32  event code to CP0; 0 = none
- cur_inst_addr_o  out  32  PC to CP0
- in_delayslot_o  out  1  delay-slot flag to CP0
- bad_addr_o  out  32  BadVAddr to CP0
- flush_o  out  1  pipeline flush pulse
- stall_o  out  1  freeze IF..MEM
- redirect_valid_o  out  1  redirect PC available
- redirect_pc_o  out  32  new fetch PC
- redirect_ready_i  in  1  fetch accepts redirect

Behaviour:
- Reset (async): state IDLE, int_pend 0, all outputs 0.
- Interrupt condition: (status[15:8] & cause[15:8]) != 0 AND status[0]=1 AND status[1]=0.
  - int_pend is set when the condition is true and cleared when it is false or the interrupt commits.
  - The interrupt attaches to the next cycle with inst_valid_m=1.
- Codes: int 0x01, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0a, Ov 0x0c, Trap 0x0d, ERET 0x0e.
- Priority, high to low: int, adel_if, ri, ov, trap, sys, bp, adel_ld, ades, eret.
- bad_addr: pc_m for adel_if; mem_addr_m for adel_ld/ades; 0 otherwise.
- States:
  - IDLE: on inst_valid_m and any event, latch code, pc_m, in_delayslot_m, bad_addr and target. Target is cp0_epc_i for ERET, EXC_VECTOR otherwise. Go to DRAIN if mem_busy_i, else COMMIT.
  - DRAIN: stall_o=1; stay while mem_busy_i; then COMMIT.
  - COMMIT: exactly one cycle. excepttype_o, cur_inst_addr_o, in_delayslot_o and bad_addr_o are driven from latches; flush_o=1; clear int_pend if code 0x01. Then REDIR.
  - REDIR: redirect_valid_o=1, redirect_pc_o=latched target, stall_o=1. Hold until redirect_valid_o and redirect_ready_i are both high, then IDLE next cycle.
- excepttype_o is nonzero only in COMMIT, because CP0 acts on every nonzero cycle. flush_o is high only in COMMIT.
- Event flags are ignored outside IDLE; younger instructions are flushed.
- redirect_pc_o and latched fields stay stable while REDIR waits.
- A multiple-flag instruction records only the top-priority code.
- ERET in a delay slot records in_delayslot_o as given; CP0 computes EPC.
- Reset asserted mid-sequence aborts immediately with no excepttype pulse.
- Latency: detection to COMMIT is 1 cycle with the bus idle; COMMIT to redirect_valid_o is 1 cycle.

Optional Feature:
- Macro EXC_CTRL_TRAP_EN.
- Defined: trap_m participates at its priority slot, code 0x0d.
- Undefined: trap_m is ignored (port kept, unused); code 0x0d is never produced.

Decomposition:
- Package exc_pkg holds:
  - exception code localparams (EXC_INT..EXC_ERET);
  - state encoding IDLE/DRAIN/COMMIT/REDIR;
  - the default vector constant.
- Sub-module exc_prio_enc: combinational priority encoder taking the flags and int_pend, returning code and bad-address select.
- Top keeps the FSM, latches and int_pend.

Test Plan:
- ov_m=1, pc_m=0xBFC00100, bus idle -> COMMIT next cycle: excepttype_o=0x0c, cur_inst_addr_o=0xBFC00100, flush 1 cycle. Then redirect_pc_o=0xBFC00380 held until ready.
- adel_ld_m with mem_addr_m=0x80000003, mem_busy_i high 3 cycles -> stall_o during DRAIN, then excepttype_o=0x04, bad_addr_o=0x80000003.
- status=0x0000FF01, cause[10]=1, inst_valid_m low 2 cycles then high -> excepttype_o=0x01 on that instruction; int_pend cleared.
- ri_m and sys_m both set, in_delayslot_m=1 -> excepttype_o=0x0a, in_delayslot_o=1; only one pulse.
- eret_m, cp0_epc_i=0xBFC00ABC, redirect_ready_i low 4 cycles -> excepttype_o=0x0e, redirect_pc_o stable at 0xBFC00ABC until handshake.
- rst asserted in REDIR -> outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the MEM-stage exception controller.
//   - exception codes written to CP0 (EXC_INT .. EXC_ERET)
//   - sequencer state encoding (IDLE / DRAIN / COMMIT / REDIR)
//   - bad-address source selects used by the priority encoder
//   - default exception vector
package exc_pkg;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TRAP = 5'h0d;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  // Where BadVAddr comes from for the selected event
  localparam logic [1:0] BAD_NONE = 2'd0;
  localparam logic [1:0] BAD_PC   = 2'd1;
  localparam logic [1:0] BAD_ADDR = 2'd2;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_REDIR  = 2'd3
  } excState_t;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: combinational priority encoder for MEM-stage events.
// Priority (high to low): int, adel_if, ri, ov, trap, sys, bp, adel_ld,
// ades, eret. Returns the winning code (0 = none) and the BadVAddr source.
// Ports:
//   intPend_i, adelIf_i, adelLd_i, ades_i, ri_i, ov_i, trap_i, sys_i,
//   bp_i, eret_i  - event inputs
//   code_o        - selected exception code
//   badSel_o      - BAD_NONE / BAD_PC / BAD_ADDR
// Configuration: EXC_CTRL_TRAP_EN enables trap_i; otherwise trap_i is ignored.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       intPend_i,
  input  logic       adelIf_i,
  input  logic       adelLd_i,
  input  logic       ades_i,
  input  logic       ri_i,
  input  logic       ov_i,
  input  logic       trap_i,
  input  logic       sys_i,
  input  logic       bp_i,
  input  logic       eret_i,
  output logic [4:0] code_o,
  output logic [1:0] badSel_o
);

  logic trapEn;

`ifdef EXC_CTRL_TRAP_EN
  assign trapEn = trap_i;
`else
  // Trap support is compiled out; the port stays so the pipeline wiring
  // does not depend on the build option.
  logic unusedTrap;
  assign unusedTrap = trap_i;
  assign trapEn     = 1'b0;
`endif

  // First match wins, so only the highest-priority event is reported
  always_comb begin
    code_o   = EXC_NONE;
    badSel_o = BAD_NONE;
    if (intPend_i) begin
      code_o = EXC_INT;
    end else if (adelIf_i) begin
      code_o   = EXC_ADEL;
      badSel_o = BAD_PC;
    end else if (ri_i) begin
      code_o = EXC_RI;
    end else if (ov_i) begin
      code_o = EXC_OV;
    end else if (trapEn) begin
      code_o = EXC_TRAP;
    end else if (sys_i) begin
      code_o = EXC_SYS;
    end else if (bp_i) begin
      code_o = EXC_BP;
    end else if (adelLd_i) begin
      code_o   = EXC_ADEL;
      badSel_o = BAD_ADDR;
    end else if (ades_i) begin
      code_o   = EXC_ADES;
      badSel_o = BAD_ADDR;
    end else if (eret_i) begin
      code_o = EXC_ERET;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception arbiter and flush/redirect sequencer.
// Selects one event per instruction, waits for the data bus to drain,
// emits a single-cycle CP0 record with a flush, then offers the redirect
// PC (exception vector or EPC) to fetch over a valid/ready handshake.
// Ports:
//   clk, rst                      - clock, async active-high reset
//   inst_valid_m, pc_m, in_delayslot_m, mem_addr_m - MEM instruction info
//   adel_if_m .. eret_m           - exception flags
//   mem_busy_i                    - outstanding data bus transaction
//   cp0_status_i/cause_i/epc_i    - current CP0 values
//   excepttype_o, cur_inst_addr_o, in_delayslot_o, bad_addr_o - CP0 record
//   flush_o, stall_o              - pipeline control
//   redirect_valid_o/pc_o/ready_i - redirect handshake to fetch
// Configuration: EXC_CTRL_TRAP_EN enables the trap exception (code 0x0d).
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int          DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid_m,
  input  logic [DATA_W-1:0] pc_m,
  input  logic              in_delayslot_m,
  input  logic [DATA_W-1:0] mem_addr_m,
  input  logic              adel_if_m,
  input  logic              adel_ld_m,
  input  logic              ades_m,
  input  logic              ri_m,
  input  logic              ov_m,
  input  logic              trap_m,
  input  logic              sys_m,
  input  logic              bp_m,
  input  logic              eret_m,
  input  logic              mem_busy_i,
  input  logic [DATA_W-1:0] cp0_status_i,
  input  logic [DATA_W-1:0] cp0_cause_i,
  input  logic [DATA_W-1:0] cp0_epc_i,
  output logic [DATA_W-1:0] excepttype_o,
  output logic [DATA_W-1:0] cur_inst_addr_o,
  output logic              in_delayslot_o,
  output logic [DATA_W-1:0] bad_addr_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              redirect_valid_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  input  logic              redirect_ready_i
);

  excState_t         state_q, state_d;
  logic              intPend_q, intPend_d;
  logic [4:0]        excCode_q, excCode_d;
  logic [DATA_W-1:0] excPc_q, excPc_d;
  logic              excDs_q, excDs_d;
  logic [DATA_W-1:0] badAddr_q, badAddr_d;
  logic [DATA_W-1:0] target_q, target_d;

  logic              intCond;
  logic [4:0]        encCode;
  logic [1:0]        encBadSel;
  logic              evtValid;
  logic              unusedCp0;

  // Only the IM/IP byte and the IE/EXL bits of CP0 matter here
  assign unusedCp0 = ^{cp0_status_i, cp0_cause_i};

  assign intCond = (|(cp0_status_i[15:8] & cp0_cause_i[15:8])) &&
                   cp0_status_i[0] && !cp0_status_i[1];

  exc_prio_enc uPrioEnc (
    .intPend_i (intPend_q),
    .adelIf_i  (adel_if_m),
    .adelLd_i  (adel_ld_m),
    .ades_i    (ades_m),
    .ri_i      (ri_m),
    .ov_i      (ov_m),
    .trap_i    (trap_m),
    .sys_i     (sys_m),
    .bp_i      (bp_m),
    .eret_i    (eret_m),
    .code_o    (encCode),
    .badSel_o  (encBadSel)
  );

  // A pending interrupt only attaches to a real instruction
  assign evtValid = inst_valid_m && (encCode != EXC_NONE);

  // State, pending-interrupt flag and the latched exception record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      intPend_q <= 1'b0;
      excCode_q <= EXC_NONE;
      excPc_q   <= '0;
      excDs_q   <= 1'b0;
      badAddr_q <= '0;
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      intPend_q <= intPend_d;
      excCode_q <= excCode_d;
      excPc_q   <= excPc_d;
      excDs_q   <= excDs_d;
      badAddr_q <= badAddr_d;
      target_q  <= target_d;
    end
  end

  // Next state; the record is captured only in IDLE so flags from younger
  // (to-be-flushed) instructions never overwrite it
  always_comb begin
    state_d   = state_q;
    excCode_d = excCode_q;
    excPc_d   = excPc_q;
    excDs_d   = excDs_q;
    badAddr_d = badAddr_q;
    target_d  = target_q;
    intPend_d = intCond && !(state_q == ST_COMMIT && excCode_q == EXC_INT);
    case (state_q)
      ST_IDLE: begin
        if (evtValid) begin
          excCode_d = encCode;
          excPc_d   = pc_m;
          excDs_d   = in_delayslot_m;
          case (encBadSel)
            BAD_PC:   badAddr_d = pc_m;
            BAD_ADDR: badAddr_d = mem_addr_m;
            default:  badAddr_d = '0;
          endcase
          target_d = (encCode == EXC_ERET) ? cp0_epc_i : EXC_VECTOR[DATA_W-1:0];
          state_d  = mem_busy_i ? ST_DRAIN : ST_COMMIT;
        end
      end
      ST_DRAIN: begin
        if (!mem_busy_i) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_REDIR;
      end
      ST_REDIR: begin
        if (redirect_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; the CP0 record is visible only during COMMIT because CP0
  // acts on every cycle in which excepttype is nonzero
  always_comb begin
    excepttype_o     = '0;
    cur_inst_addr_o  = '0;
    in_delayslot_o   = 1'b0;
    bad_addr_o       = '0;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      ST_DRAIN: stall_o = 1'b1;
      ST_COMMIT: begin
        excepttype_o    = {{(DATA_W-5){1'b0}}, excCode_q};
        cur_inst_addr_o = excPc_q;
        in_delayslot_o  = excDs_q;
        bad_addr_o      = badAddr_q;
        flush_o         = 1'b1;
      end
      ST_REDIR: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        stall_o          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
